// File: rtl/bsg_credit_sender_ctrl.sv
// rtl/bsg_credit_sender_ctrl.sv - credit-gated sender front end for an up/down credit counter (optional BSG_CREDIT_SENDER_ERR_EN adds err_o)
module bsg_credit_sender_ctrl #(
  parameter int data_width_p = 32,
  parameter int max_val_p    = 200,
  parameter int ret_max_p    = 3,
  parameter int pend_width_p = 9
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  input  logic                    credit_v_i,
  input  logic [1:0]              credit_num_i,
  output logic                    ctr_reset_o,
  output logic                    ctr_up_o,
  output logic                    ctr_down_o,
  input  logic [7:0]              ctr_count_i,
`ifdef BSG_CREDIT_SENDER_ERR_EN
  output logic                    err_o,
`endif
  output logic                    idle_o
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] max_cnt_c = 8'(max_val_p);
  localparam logic [1:0] ret_max_c = 2'(ret_max_p);

  state_e                  state_r, state_n;
  logic                    init_cnt_r, init_cnt_n;
  logic                    run;
  logic [pend_width_p-1:0] pend_r;
  logic [pend_width_p-1:0] pend_add;
  logic [1:0]              add_n;

  // State register and counter-reset sequencing count
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= ST_INIT;
      init_cnt_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      init_cnt_r <= init_cnt_n;
    end
  end

  // Next-state: hold the counter in reset two cycles, settle one, then run
  always_comb begin
    state_n     = state_r;
    init_cnt_n  = init_cnt_r;
    ctr_reset_o = 1'b0;
    run         = 1'b0;
    case (state_r)
      ST_INIT: begin
        ctr_reset_o = 1'b1;
        if (init_cnt_r) state_n = ST_SYNC;
        else            init_cnt_n = 1'b1;
      end
      ST_SYNC: state_n = ST_RUN;
      ST_RUN:  run = 1'b1;
      default: state_n = ST_INIT;
    endcase
  end

  assign ready_o    = run & (ctr_count_i != 8'd0);
  assign ctr_down_o = v_i & ready_o;
  assign ctr_up_o   = run & (pend_r != '0);
  assign idle_o     = run & (pend_r == '0) & (ctr_count_i == max_cnt_c);

  // Returns beyond the per-cycle maximum are clamped; returns outside RUN are dropped
  assign add_n = (!(run & credit_v_i)) ? 2'd0 :
                 (credit_num_i > ret_max_c) ? ret_max_c : credit_num_i;

`ifdef BSG_CREDIT_SENDER_ERR_EN
  logic                    pend_carry;
  logic [pend_width_p:0]   sum_chk;
  logic                    err_r;
  localparam logic [pend_width_p:0] max_sum_c = (pend_width_p+1)'(max_val_p);

  assign {pend_carry, pend_add} = {1'b0, pend_r} + (pend_width_p+1)'(add_n);
  assign sum_chk = (pend_width_p+1)'(ctr_count_i) + {1'b0, pend_r};

  // Sticky protocol-error flag: overflow, underflow guard, accumulator carry
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_r <= 1'b0;
    else if ((ctr_up_o & (sum_chk > max_sum_c)) |
             (ctr_down_o & (ctr_count_i == 8'd0)) |
             pend_carry)
      err_r <= 1'b1;
  end

  assign err_o = err_r;
`else
  assign pend_add = pend_r + pend_width_p'(add_n);
`endif

  // Pending-credit accumulator: add returns, drain one per cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pend_r <= '0;
    else if (run)   pend_r <= pend_add - pend_width_p'(ctr_up_o);
  end

  // Registered downstream word; payload holds when nothing is sent
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
    end else begin
      v_o <= ctr_down_o;
      if (ctr_down_o) data_o <= data_i;
    end
  end

endmodule

// File: tb/tb_bsg_credit_sender_ctrl.sv
// tb/tb_bsg_credit_sender_ctrl.sv - randomized self-checking bench for bsg_credit_sender_ctrl
module tb_bsg_credit_sender_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic        v_o;
  logic [31:0] data_o;
  logic        credit_v_i;
  logic [1:0]  credit_num_i;
  logic        ctr_reset_o;
  logic        ctr_up_o;
  logic        ctr_down_o;
  logic [7:0]  ctr_count;
  logic        idle_o;
`ifdef BSG_CREDIT_SENDER_ERR_EN
  logic        err_o;
`endif

  int checks = 0;
  int passes = 0;

  // reference model state
  int          phase;
  int          m_pend;
  int          m_cnt;
  int          owed;
  logic        m_vo;
  logic [31:0] m_data;
  logic        m_err;

  always #5 clk = ~clk;

  bsg_credit_sender_ctrl dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .v_i          (v_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .v_o          (v_o),
    .data_o       (data_o),
    .credit_v_i   (credit_v_i),
    .credit_num_i (credit_num_i),
    .ctr_reset_o  (ctr_reset_o),
    .ctr_up_o     (ctr_up_o),
    .ctr_down_o   (ctr_down_o),
    .ctr_count_i  (ctr_count),
`ifdef BSG_CREDIT_SENDER_ERR_EN
    .err_o        (err_o),
`endif
    .idle_o       (idle_o)
  );

  // the 8-bit up/down credit counter downstream of the DUT
  always @(posedge clk) begin
    if (ctr_reset_o) ctr_count <= 8'd200;
    else             ctr_count <= ctr_count + {7'd0, ctr_up_o} - {7'd0, ctr_down_o};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    phase  = 0;
    m_pend = 0;
    m_cnt  = 200;
    owed   = 0;
    m_vo   = 1'b0;
    m_data = 32'd0;
    m_err  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    v_i = 1'b0; data_i = 32'd0; credit_v_i = 1'b0; credit_num_i = 2'd0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_v_o", {31'd0, v_o}, 32'd0);
    check("rst_data_o", data_o, 32'd0);
    check("rst_ctr_reset", {31'd0, ctr_reset_o}, 32'd1);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_up", {31'd0, ctr_up_o}, 32'd0);
    check("rst_down", {31'd0, ctr_down_o}, 32'd0);
    check("rst_idle", {31'd0, idle_o}, 32'd0);
`ifdef BSG_CREDIT_SENDER_ERR_EN
    check("rst_err", {31'd0, err_o}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  // one clock cycle: drive, check combinational outputs, advance model, check registered outputs
  task automatic step(input logic v, input logic [31:0] d, input logic cv, input int cn);
    bit run, e_up, e_down, e_ready, e_idle;
    int add;
    @(negedge clk);
    v_i = v; data_i = d; credit_v_i = cv; credit_num_i = 2'(cn);
    #1;
    run     = (phase >= 3);
    e_ready = run && (m_cnt != 0);
    e_down  = v && e_ready;
    e_up    = run && (m_pend != 0);
    e_idle  = run && (m_pend == 0) && (m_cnt == 200);
    add     = (run && cv) ? cn : 0;
    check("ctr_reset", {31'd0, ctr_reset_o}, {31'd0, phase < 2});
    check("ready", {31'd0, ready_o}, {31'd0, e_ready});
    check("down", {31'd0, ctr_down_o}, {31'd0, e_down});
    check("up", {31'd0, ctr_up_o}, {31'd0, e_up});
    check("idle", {31'd0, idle_o}, {31'd0, e_idle});
    check("count", {24'd0, ctr_count}, 32'(m_cnt));
`ifdef BSG_CREDIT_SENDER_ERR_EN
    check("err", {31'd0, err_o}, {31'd0, m_err});
    if (e_up && (m_cnt + m_pend > 200)) m_err = 1'b1;
    if (e_down && m_cnt == 0)           m_err = 1'b1;
    if (run && (m_pend + add > 511))    m_err = 1'b1;
`endif
    m_vo = e_down;
    if (e_down) begin
      m_data = d;
      owed   = owed + 1;
    end
    owed = owed - add;
    if (phase < 2)  m_cnt = 200;
    else if (run)   m_cnt = (m_cnt + (e_up ? 1 : 0) - (e_down ? 1 : 0)) % 256;
    if (run)        m_pend = (m_pend + add - (e_up ? 1 : 0)) % 512;
    if (phase < 3)  phase = phase + 1;
    @(posedge clk);
    #1;
    check("v_o", {31'd0, v_o}, {31'd0, m_vo});
    check("data_o", data_o, m_data);
  endtask

  initial begin
    int cn;
    reset_n = 1'b1;
    v_i = 1'b0; data_i = 32'd0; credit_v_i = 1'b0; credit_num_i = 2'd0;
    model_reset();
    do_reset();

    // reset release into RUN
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 0);

    // 200 back-to-back sends then starvation with v_i held high
    for (int i = 0; i < 204; i++) step(1'b1, $urandom, 1'b0, 0);

    // single return of 3 at count 0
    step(1'b1, $urandom, 1'b1, 3);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 0);

    // refill to 100 and drain the accumulator
    for (int i = 0; i < 32; i++) step(1'b0, 32'd0, 1'b1, 3);
    step(1'b0, 32'd0, 1'b1, 1);
    for (int i = 0; i < 80; i++) step(1'b0, 32'd0, 1'b0, 0);

    // continuous send with one credit returned every cycle
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 0);

    // returns of 3 then 2 on consecutive cycles
    step(1'b0, 32'd0, 1'b1, 3);
    step(1'b0, 32'd0, 1'b1, 2);
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 0);

    // reset mid-burst with two credits pending
    step(1'b1, $urandom, 1'b1, 3);
    step(1'b1, $urandom, 1'b0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 32'd0, 1'b0, 0);

    // randomized traffic within the credit protocol
    for (int i = 0; i < 400; i++) begin
      cn = $urandom_range(0, 3);
      if (cn > owed) cn = owed;
      step(($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)), cn);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 32'd0, 1'b0, 0);

`ifdef BSG_CREDIT_SENDER_ERR_EN
    // surplus credit at full count trips the sticky error
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 0);
    step(1'b0, 32'd0, 1'b1, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b0, 0);
    check("err_sticky", {31'd0, err_o}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
